// File: rtl/fetch_queue_unit.sv
// Instruction prefetch queue: fetches sequentially from a combinational
// instruction memory into a small circular buffer. Redirects flush the buffer
// and restart fetch at the target; stalls block only the consumer side.
module fetch_queue_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'd0,
  parameter int              PC_STEP  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [XLEN-1:0]          imem_addr,
  input  logic [XLEN-1:0]          imem_rdata,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  input  logic                     stall,
  input  logic                     deq,
  output logic                     out_valid,
  output logic [XLEN-1:0]          out_instr,
  output logic [XLEN-1:0]          out_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int              PW      = $clog2(DEPTH);
  localparam int              CW      = PW + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
  localparam logic [XLEN-1:0] STEP_C  = XLEN'(PC_STEP);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] pc_mem_q    [DEPTH];
  logic [XLEN-1:0] instr_mem_q [DEPTH];
  logic            push_s;
  logic            pop_s;

  // Head entry is presented directly from storage; occupancy gives validity.
  always_comb begin
    imem_addr = fetch_pc_q;
    out_valid = (count_q != {CW{1'b0}});
    out_instr = instr_mem_q[head_q];
    out_pc    = pc_mem_q[head_q];
    count     = count_q;
  end

  // Redirect overrides everything; a pop frees a slot for a same-cycle push.
  always_comb begin
    pop_s  = deq && out_valid && !stall && !redirect_valid;
    push_s = !redirect_valid && ((count_q < DEPTH_C) || pop_s);
  end

  // Next-state for fetch PC, pointers and occupancy.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      head_d     = tail_q;
      count_d    = {CW{1'b0}};
    end else begin
      if (push_s) begin
        tail_d     = tail_q + PW'(1);
        fetch_pc_d = fetch_pc_q + STEP_C;
      end else begin
        tail_d     = tail_q;
      end
      if (pop_s) begin
        head_d = head_q + PW'(1);
      end else begin
        head_d = head_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      head_q     <= {PW{1'b0}};
      tail_q     <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Entry storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge clk) begin
    if (push_s) begin
      pc_mem_q[tail_q]    <= fetch_pc_q;
      instr_mem_q[tail_q] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: fill, streaming, redirect, stall,
// PC wrap (16-bit instance) and asynchronous reset between edges.
`timescale 1ns/1ps
module tb_fetch_queue_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, out_instr, out_pc;
  logic        redirect_valid = 1'b0, stall = 1'b0, deq = 1'b0, out_valid;
  logic [2:0]  count;

  logic [15:0] imem_addr2, imem_rdata2, out_instr2, out_pc2;
  logic        deq2 = 1'b0, out_valid2;
  logic [2:0]  count2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Memory models: word at address A is A + 0x100.
  assign imem_rdata  = imem_addr + 32'h100;
  assign imem_rdata2 = imem_addr2 + 16'h0100;

  fetch_queue_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'd0), .PC_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .deq(deq), .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .count(count)
  );

  fetch_queue_unit #(.XLEN(16), .DEPTH(4), .RESET_PC(16'hFFFC), .PC_STEP(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .redirect_valid(1'b0), .redirect_pc(16'h0000), .stall(1'b0),
    .deq(deq2), .out_valid(out_valid2), .out_instr(out_instr2), .out_pc(out_pc2),
    .count(count2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1: pulse reset low, release before the next edge.
  task automatic pulse_reset();
    deq = 1'b0; stall = 1'b0; redirect_valid = 1'b0; deq2 = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    redirect_pc = 32'h0;
    #1;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %0h want 0", imem_addr); end
    tick(); tick();
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_hold_count: got %0d want 0", count); end
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    for (int n = 1; n <= 4; n++) begin
      tick();
      n_checks++; if (count !== 3'(n)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d want %0d", n, count, n); end
    end
    n_checks++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL fill_pc: got %0h want 0", out_pc); end
    n_checks++; if (out_instr !== 32'h100) begin n_fail++; $display("FAIL fill_instr: got %0h want 100", out_instr); end
    n_checks++; if (imem_addr !== 32'd16) begin n_fail++; $display("FAIL fill_addr: got %0h want 10", imem_addr); end
    tick(); tick();
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_hold_count: got %0d want 4", count); end
    n_checks++; if (imem_addr !== 32'd16) begin n_fail++; $display("FAIL full_hold_addr: got %0h want 10", imem_addr); end
  endtask

  task automatic test_back_to_back();
    deq = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_checks++; if (out_pc !== 32'(4 * k)) begin n_fail++; $display("FAIL stream_pc[%0d]: got %0h want %0h", k, out_pc, 4 * k); end
      n_checks++; if (out_instr !== 32'(4 * k + 256)) begin n_fail++; $display("FAIL stream_instr[%0d]: got %0h want %0h", k, out_instr, 4 * k + 256); end
      n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL stream_count[%0d]: got %0d want 4", k, count); end
    end
    deq = 1'b0;
  endtask

  task automatic test_redirect();
    pulse_reset();
    repeat (4) tick();
    deq = 1'b1;
    tick(); tick();
    n_checks++; if (out_pc !== 32'd8) begin n_fail++; $display("FAIL redir_pre_pc: got %0h want 8", out_pc); end
    redirect_valid = 1'b1; redirect_pc = 32'h40; stall = 1'b1;
    tick();
    redirect_valid = 1'b0; deq = 1'b0; stall = 1'b0;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL redir_count0: got %0d want 0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_valid0: got %0b want 0", out_valid); end
    n_checks++; if (imem_addr !== 32'h40) begin n_fail++; $display("FAIL redir_addr: got %0h want 40", imem_addr); end
    tick();
    n_checks++; if (out_pc !== 32'h40) begin n_fail++; $display("FAIL redir_pc: got %0h want 40", out_pc); end
    n_checks++; if (out_instr !== 32'h140) begin n_fail++; $display("FAIL redir_instr: got %0h want 140", out_instr); end
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL redir_count1: got %0d want 1", count); end
  endtask

  task automatic test_stall();
    pulse_reset();
    tick(); tick();
    n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL stall_pre_count: got %0d want 2", count); end
    stall = 1'b1; deq = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      n_checks++; if (count !== ((c == 1) ? 3'd3 : 3'd4)) begin n_fail++; $display("FAIL stall_count[%0d]: got %0d want %0d", c, count, (c == 1) ? 3 : 4); end
      n_checks++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL stall_pc[%0d]: got %0h want 0", c, out_pc); end
    end
    n_checks++; if (imem_addr !== 32'd16) begin n_fail++; $display("FAIL stall_addr: got %0h want 10", imem_addr); end
    stall = 1'b0; deq = 1'b0;
  endtask

  task automatic test_wrap();
    logic [15:0] exp_pc [4];
    exp_pc[0] = 16'hFFFC; exp_pc[1] = 16'h0000; exp_pc[2] = 16'h0004; exp_pc[3] = 16'h0008;
    pulse_reset();
    repeat (4) tick();
    n_checks++; if (count2 !== 3'd4) begin n_fail++; $display("FAIL wrap_count: got %0d want 4", count2); end
    n_checks++; if (imem_addr2 !== 16'h000C) begin n_fail++; $display("FAIL wrap_addr: got %0h want c", imem_addr2); end
    deq2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (out_pc2 !== exp_pc[i]) begin n_fail++; $display("FAIL wrap_pc[%0d]: got %0h want %0h", i, out_pc2, exp_pc[i]); end
      n_checks++; if (out_instr2 !== exp_pc[i] + 16'h0100) begin n_fail++; $display("FAIL wrap_instr[%0d]: got %0h want %0h", i, out_instr2, exp_pc[i] + 16'h0100); end
      tick();
    end
    deq2 = 1'b0;
  endtask

  task automatic test_async_reset();
    pulse_reset();
    repeat (3) tick();
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL areset_pre_count: got %0d want 3", count); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL areset_count: got %0d want 0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid: got %0b want 0", out_valid); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL areset_addr: got %0h want 0", imem_addr); end
    rst_n = 1'b1;
    tick();
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL areset_push_count: got %0d want 1", count); end
    n_checks++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL areset_push_pc: got %0h want 0", out_pc); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_back_to_back();
    test_redirect();
    test_stall();
    test_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
